// File: rtl/seq_shl_if.sv
// Handshake/data bundle for the sequential left shifter.
// The requester drives start/a/sh_amt; the shifter returns d/ovf/busy/done.
interface seq_shl_if #(
    parameter int DATAWIDTH = 8
);
    logic                 start;
    logic [DATAWIDTH-1:0] a;
    logic [DATAWIDTH-1:0] sh_amt;
    logic [DATAWIDTH-1:0] d;
    logic                 ovf;
    logic                 busy;
    logic                 done;

    modport master (output start, a, sh_amt, input d, ovf, busy, done);
    modport slave  (input start, a, sh_amt, output d, ovf, busy, done);
endinterface

// File: rtl/seq_shl.sv
// Multi-cycle logical left shifter: one bit per clock, start/busy/done handshake,
// sticky overflow when a 1 leaves the MSB.
module seq_shl #(
    parameter int DATAWIDTH = 8
) (
    input  logic       Clk,
    input  logic       Rst,
    seq_shl_if.slave   bus
);
    localparam int CW = $clog2(DATAWIDTH + 1);

    localparam logic [DATAWIDTH-1:0] DW_VAL  = DATAWIDTH[DATAWIDTH-1:0];
    localparam logic [CW-1:0]        CNT_MAX = DATAWIDTH[CW-1:0];

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state_q, state_nx;
    logic [DATAWIDTH-1:0] d_q, d_nx;
    logic                 ovf_q, ovf_nx;
    logic [CW-1:0]        cnt_q, cnt_nx;
    logic [CW-1:0]        n_clamp;

    // Amounts at or beyond the width all behave as a full-width shift.
    assign n_clamp = (bus.sh_amt >= DW_VAL) ? CNT_MAX : bus.sh_amt[CW-1:0];

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= IDLE;
            d_q     <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_nx;
            d_q     <= d_nx;
            ovf_q   <= ovf_nx;
            cnt_q   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state_q;
        d_nx     = d_q;
        ovf_nx   = ovf_q;
        cnt_nx   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    d_nx     = bus.a;
                    ovf_nx   = 1'b0;
                    cnt_nx   = n_clamp;
                    state_nx = (n_clamp == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                d_nx   = {d_q[DATAWIDTH-2:0], 1'b0};
                ovf_nx = ovf_q | d_q[DATAWIDTH-1];
                cnt_nx = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign bus.d    = d_q;
    assign bus.ovf  = ovf_q;
    assign bus.busy = (state_q != IDLE);
    assign bus.done = (state_q == DONE);
endmodule

// File: tb/tb_seq_shl.sv
// Scoreboard bench for seq_shl: stimulus pushes expected results, a negedge
// monitor pops and compares them whenever done is seen.
module tb_seq_shl;
    localparam int DW = 8;

    typedef struct {
        logic [DW-1:0] d;
        logic          ovf;
        time           t;
    } exp_t;

    logic Clk;
    logic Rst;
    int   checks;
    int   errors;
    exp_t sb[$];

    seq_shl_if #(.DATAWIDTH(DW)) bus ();

    seq_shl #(.DATAWIDTH(DW)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: widen, shift by the clamped amount, split into kept and lost bits.
    function automatic exp_t model(input logic [DW-1:0] a, input logic [DW-1:0] sh, input time t0);
        exp_t e;
        int n;
        logic [2*DW-1:0] full;
        n     = (int'(sh) > DW) ? DW : int'(sh);
        full  = {{DW{1'b0}}, a} << n;
        e.d   = full[DW-1:0];
        e.ovf = |full[2*DW-1:DW];
        e.t   = t0 + 10 * (n + 1);
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge Clk) begin
        if (Rst === 1'b1 && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(bus.d), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("d", 32'(bus.d), 32'(e.d));
                chk("ovf", 32'(bus.ovf), 32'(e.ovf));
                chk("done_time", 32'($time), 32'(e.t));
            end
        end
    end

    // Called at a negedge; returns at the first negedge with busy low.
    task automatic wait_idle();
        int k;
        k = 0;
        while (bus.busy === 1'b1 && k < 40) begin
            @(negedge Clk);
            k++;
        end
        if (k >= 40) chk("busy_timeout", 32'(bus.busy), 32'h0);
    endtask

    task automatic do_op(input logic [DW-1:0] a, input logic [DW-1:0] sh);
        bus.start  = 1'b1;
        bus.a      = a;
        bus.sh_amt = sh;
        sb.push_back(model(a, sh, $time));
        @(negedge Clk);
        chk("busy_after_start", 32'(bus.busy), 32'h1);
        bus.start  = 1'b0;
        bus.a      = DW'($urandom);
        bus.sh_amt = DW'($urandom);
        wait_idle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        bus.start  = 1'b1;
        bus.a      = DW'($urandom);
        bus.sh_amt = DW'($urandom);
        Rst = 1'b0;
        #1;
        chk("rst_d", 32'(bus.d), 32'h0);
        chk("rst_ovf", 32'(bus.ovf), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_done", 32'(bus.done), 32'h0);
        repeat (3) @(negedge Clk);
        chk("rst_hold_d", 32'(bus.d), 32'h0);
        chk("rst_hold_busy", 32'(bus.busy), 32'h0);
        bus.start = 1'b0;
        Rst = 1'b1;
        @(negedge Clk);

        // Directed cases
        do_op(8'h96, 8'd3);
        @(negedge Clk);
        chk("hold_d", 32'(bus.d), 32'hB0);
        chk("hold_ovf", 32'(bus.ovf), 32'h1);
        do_op(8'h0F, 8'd4);
        do_op(8'h5A, 8'd0);
        do_op(8'h01, 8'd200);
        do_op(8'h00, 8'd8);

        // Start while busy is ignored; start in the first idle cycle is taken.
        bus.start  = 1'b1;
        bus.a      = 8'h81;
        bus.sh_amt = 8'd2;
        sb.push_back(model(8'h81, 8'd2, $time));
        @(negedge Clk);
        bus.a      = 8'hFF;
        bus.sh_amt = 8'd1;
        for (int i = 0; i < 10 && bus.busy === 1'b1; i++) @(negedge Clk);
        chk("busy_start_d", 32'(bus.d), 32'h04);
        chk("busy_start_ovf", 32'(bus.ovf), 32'h1);
        do_op(8'h03, 8'd1);

        // Reset mid-operation aborts with no done pulse.
        bus.start  = 1'b1;
        bus.a      = 8'hFF;
        bus.sh_amt = 8'd6;
        @(negedge Clk);
        bus.start = 1'b0;
        repeat (2) @(negedge Clk);
        #2;
        Rst = 1'b0;
        #1;
        chk("abort_d", 32'(bus.d), 32'h0);
        chk("abort_ovf", 32'(bus.ovf), 32'h0);
        chk("abort_busy", 32'(bus.busy), 32'h0);
        sb.delete();
        bus.start = 1'b1;
        repeat (2) @(negedge Clk);
        bus.start = 1'b0;
        Rst = 1'b1;
        @(negedge Clk);
        chk("post_abort_busy", 32'(bus.busy), 32'h0);
        do_op(8'h03, 8'd1);

        // Randomized operations with random idle gaps.
        for (int i = 0; i < 60; i++) begin
            logic [DW-1:0] ra, rs;
            ra = DW'($urandom);
            rs = ($urandom_range(0, 3) == 0) ? DW'($urandom) : DW'($urandom_range(0, DW + 2));
            do_op(ra, rs);
            repeat ($urandom_range(0, 2)) @(negedge Clk);
        end

        repeat (3) @(negedge Clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
